// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter in front of one shared multi-cycle divider.
// Up to four requesters present operand pairs; one is served per transaction.
// The winner's operands are latched, the divider is started, and the result
// is returned with a one-hot response strobe to that requester.
// Optional watchdog on the divider wait: define DIV_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction; pick the next winner when any req is high
// ISSUE | gnt and div_start high for one cycle, operands presented
// WAIT  | waiting for div_done / div_dbz (or the watchdog, if enabled)
// RESP  | rsp_valid high for one cycle with captured result
module div_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  x_in,
  input  logic [NREQ*WIDTH-1:0]  y_in,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       q_out,
  output logic [WIDTH-1:0]       r_out,
  output logic                   dbz_out,
  output logic                   timeout_err,
  output logic                   busy,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_x,
  output logic [WIDTH-1:0]       div_y,
  input  logic [WIDTH-1:0]       div_q,
  input  logic [WIDTH-1:0]       div_r,
  input  logic                   div_done,
  input  logic                   div_dbz
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    rr_pick, cand;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_q, rsp_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             wd_hit;

  // Round-robin pick: first requester after last_q, wrapping; scanning from
  // the far end lets the nearest candidate overwrite the others.
  always_comb begin
    rr_pick = last_q;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (req[cand]) rr_pick = cand;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = '0;
    rsp_d   = '0;
    start_d = 1'b0;
    busy_d  = busy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ISSUE;
          win_d   = rr_pick;
          gnt_d   = ONE << rr_pick;
          start_d = 1'b1;
          busy_d  = 1'b1;
          dx_d    = x_in[int'(rr_pick)*WIDTH +: WIDTH];
          dy_d    = y_in[int'(rr_pick)*WIDTH +: WIDTH];
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done || div_dbz) begin
          state_d = S_RESP;
          rsp_d   = ONE << win_q;
          dbz_d   = div_dbz;
          q_d     = div_dbz ? '0 : div_q;
          r_d     = div_dbz ? '0 : div_r;
        end else if (wd_hit) begin
          state_d = S_RESP;
          rsp_d   = ONE << win_q;
          dbz_d   = 1'b0;
          q_d     = '0;
          r_d     = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        last_d  = win_q;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      rsp_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      rsp_q   <= rsp_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(WIDTH + 5);
  localparam logic [CW-1:0] WD_LAST = CW'(WIDTH + 3);

  logic [CW-1:0] wd_q, wd_d;
  logic          to_q, to_d;

  // The increment out of WD_LAST is the one that reaches WIDTH+4.
  assign wd_hit = (wd_q == WD_LAST);

  // Watchdog next-state: cleared in ISSUE, counts WAIT cycles.
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (state_q == S_ISSUE) wd_d = '0;
    else if (state_q == S_WAIT) wd_d = wd_q + CW'(1);
    if (state_q == S_WAIT && (div_done || div_dbz || wd_hit))
      to_d = !(div_done || div_dbz);
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign timeout_err = to_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_q;
  assign q_out     = q_q;
  assign r_out     = r_q;
  assign dbz_out   = dbz_q;
  assign busy      = busy_q;
  assign div_start = start_q;
  assign div_x     = dx_q;
  assign div_y     = dy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed and randomized transactions against div_arbiter,
// with a stub divider whose latency is set per transaction and a reference
// model for arbitration order and results.
module tb_div_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [31:0]      x_in = '0;
  logic [31:0]      y_in = '0;
  logic [3:0]       gnt, rsp_valid;
  logic [7:0]       q_out, r_out, div_x, div_y;
  logic             dbz_out, timeout_err, busy, div_start;
  logic [7:0]       div_q = '0;
  logic [7:0]       div_r = '0;
  logic             div_done = 1'b0;
  logic             div_dbz = 1'b0;

  div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .q_out(q_out), .r_out(r_out),
    .dbz_out(dbz_out), .timeout_err(timeout_err), .busy(busy),
    .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_q(div_q), .div_r(div_r), .div_done(div_done), .div_dbz(div_dbz)
  );

  always #5 clk = ~clk;

  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Stub divider: result strobe appears stub_lat cycles after div_start is
  // sampled (0 = on the same edge); stub_never suppresses it entirely.
  int         stub_lat = 0;
  bit         stub_never = 1'b0;
  int         s_cnt = 0;
  logic [7:0] s_x = '0, s_y = '0;
  wire        fire_now = !stub_never && (div_start ? (stub_lat == 0) : (s_cnt == 1));
  wire [7:0]  fx = div_start ? div_x : s_x;
  wire [7:0]  fy = div_start ? div_y : s_y;

  always @(posedge clk) begin
    if (div_start) begin
      s_x   <= div_x;
      s_y   <= div_y;
      s_cnt <= stub_lat;
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
    end
    div_done <= fire_now && (fy != 0);
    div_dbz  <= fire_now && (fy == 0);
    div_q    <= (fire_now && fy != 0) ? fx / fy : 8'hA5;
    div_r    <= (fire_now && fy != 0) ? fx % fy : 8'h5A;
  end

  int n_chk = 0;
  int n_err = 0;

  // model state
  int         last_m = 3;
  int         cur_w = 0;
  int         t_start = 0;
  logic [7:0] ex_x = '0, ex_y = '0;
  logic [7:0] prev_q = '0, prev_r = '0;
  logic [3:0] one4 = 4'b0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return last;
  endfunction

  function automatic logic [7:0] slice(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 4'b0);
    chk("rst_rsp", rsp_valid, 4'b0);
    chk("rst_start", div_start, 1'b0);
    chk("rst_divx", div_x, 8'h0);
    chk("rst_divy", div_y, 8'h0);
    chk("rst_q", q_out, 8'h0);
    chk("rst_r", r_out, 8'h0);
    chk("rst_dbz", dbz_out, 1'b0);
    chk("rst_to", timeout_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 3;
    prev_q = '0;
    prev_r = '0;
  endtask

  // Called in IDLE with req already driven; returns in the first WAIT cycle.
  task automatic wait_gnt();
    int n;
    n = 0;
    cur_w = rr_model(req, last_m);
    ex_x  = slice(x_in, cur_w);
    ex_y  = slice(y_in, cur_w);
    while (gnt === 4'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    t_start = cyc_now;
    chk("gnt_lat", n, 1);
    chk("gnt", gnt, one4 << cur_w);
    chk("issue_start", div_start, 1'b1);
    chk("issue_busy", busy, 1'b1);
    chk("issue_divx", div_x, ex_x);
    chk("issue_divy", div_y, ex_y);
    chk("issue_qhold", q_out, prev_q);
    @(negedge clk);
    chk("gnt_pulse", gnt, 4'b0);
    chk("start_pulse", div_start, 1'b0);
    chk("wait_busy", busy, 1'b1);
  endtask

  task automatic wait_rsp(input int exp_lat, input bit to_exp);
    logic [7:0] eq, er;
    logic       ed;
    ed = !to_exp && (ex_y == 0);
    eq = (to_exp || ed) ? 8'h0 : ex_x / ex_y;
    er = (to_exp || ed) ? 8'h0 : ex_x % ex_y;
    while (rsp_valid === 4'b0 && (cyc_now - t_start) < 40) @(negedge clk);
    chk("rsp_lat", cyc_now - t_start, exp_lat);
    chk("rsp_valid", rsp_valid, one4 << cur_w);
    chk("wait_divx_stable", div_x, ex_x);
    chk("wait_divy_stable", div_y, ex_y);
    chk("q_out", q_out, eq);
    chk("r_out", r_out, er);
    chk("dbz_out", dbz_out, ed);
    chk("timeout_err", timeout_err, to_exp);
    prev_q = eq;
    prev_r = er;
    last_m = cur_w;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 4'b0);
    chk("idle_busy", busy, 1'b0);
    chk("q_hold", q_out, prev_q);
    chk("r_hold", r_out, prev_r);
  endtask

  initial begin
    int t_prev, nxt_lat, cur_lat, seen;
    logic [3:0]  nreq;
    logic [31:0] nx, ny;

    do_reset();

    // single request, 7/2
    x_in = 32'h0000_0007; y_in = 32'h0000_0002; stub_lat = 3;
    req = 4'b0001;
    wait_gnt();
    req = 4'b0000;
    wait_rsp(3 + 2, 1'b0);

    // divide by zero on requester 2
    x_in = {8'd0, 8'd200, 8'd0, 8'd0}; y_in = 32'h0; stub_lat = 2;
    req = 4'b0100;
    wait_gnt();
    req = 4'b0000;
    wait_rsp(2 + 2, 1'b0);

    // grant to 0, then 0101 must serve 2 before 0
    x_in = {8'd9, 8'd100, 8'd3, 8'd50}; y_in = {8'd2, 8'd7, 8'd1, 8'd6}; stub_lat = 1;
    req = 4'b0001;
    wait_gnt();
    req = 4'b0000;
    wait_rsp(1 + 2, 1'b0);
    req = 4'b0101;
    wait_gnt();
    chk("simul_first", cur_w, 2);
    wait_rsp(1 + 2, 1'b0);
    wait_gnt();
    req = 4'b0000;
    wait_rsp(1 + 2, 1'b0);

    // fairness with all requesters held, fastest divider
    do_reset();
    x_in = {8'd255, 8'd77, 8'd13, 8'd250}; y_in = {8'd16, 8'd5, 8'd13, 8'd7};
    stub_lat = 0;
    req = 4'b1111;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt();
      chk("rr_order", cur_w, i % 4);
      if (i > 0) chk("rr_spacing", t_start - t_prev, 4);
      t_prev = t_start;
      if (i == 4) req = 4'b0000;
      wait_rsp(0 + 2, 1'b0);
    end

    // randomized traffic; new requests and operands change during WAIT
    cur_lat = $urandom_range(0, 5);
    stub_lat = cur_lat;
    req  = 4'($urandom_range(1, 15));
    x_in = $urandom;
    y_in = $urandom;
    for (int i = 0; i < 24; i++) begin
      wait_gnt();
      nxt_lat = $urandom_range(0, 5);
      nreq = (i == 23) ? 4'b0000 : 4'($urandom_range(1, 15));
      nx = $urandom;
      ny = $urandom;
      if ($urandom_range(0, 4) == 0) ny[8*$urandom_range(0, 3) +: 8] = 8'h0;
      req = nreq; x_in = nx; y_in = ny; stub_lat = nxt_lat;
      wait_rsp(cur_lat + 2, 1'b0);
      cur_lat = nxt_lat;
    end

    // reset two cycles after div_start aborts the transaction
    x_in = {8'd0, 8'd0, 8'd40, 8'd0}; y_in = {8'd0, 8'd0, 8'd3, 8'd0}; stub_lat = 6;
    req = 4'b0010;
    wait_gnt();
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp", rsp_valid, 4'b0);
    chk("abort_divx", div_x, 8'h0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 3; prev_q = '0; prev_r = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0 || busy !== 1'b0) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    // divider that never answers
    x_in = 32'h0000_0021; y_in = 32'h0000_0004;
    stub_never = 1'b1;
    req = 4'b0001;
    wait_gnt();
    req = 4'b0000;
`ifdef DIV_ARB_TIMEOUT_EN
    wait_rsp(WIDTH + 5, 1'b1);
`else
    repeat (30) @(negedge clk);
    chk("stuck_busy", busy, 1'b1);
    chk("stuck_rsp", rsp_valid, 4'b0);
    chk("stuck_to", timeout_err, 1'b0);
    do_reset();
`endif
    stub_never = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
